// File: rtl/falco_dmem_responder.sv
// Data-memory responder for the Falco load/store ports: word SRAM with a
// deterministic miss injector that drives load_dmem_stall and the fill path.
module falco_dmem_responder #(
  parameter int XLEN_WIDTH = 32,
  parameter int DEPTH      = 4096,
  parameter int TAG_W      = 4,
  parameter int MISS_EVERY = 8,
  parameter int MISS_LAT   = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ld_req_valid,
  output logic                    ld_req_ready,
  input  logic [XLEN_WIDTH-1:0]   ld_req_addr,
  input  logic [TAG_W-1:0]        ld_req_tag,
  output logic                    ld_hit_valid,
  output logic                    ld_hit,
  output logic [TAG_W-1:0]        ld_hit_tag,
  output logic                    ld_data_valid,
  output logic [XLEN_WIDTH-1:0]   ld_data,
  output logic [TAG_W-1:0]        ld_data_tag,
  output logic                    load_dmem_stall,
  input  logic                    st_req_valid,
  output logic                    st_req_ready,
  input  logic [XLEN_WIDTH-1:0]   st_req_addr,
  input  logic [XLEN_WIDTH-1:0]   st_req_data,
  input  logic [XLEN_WIDTH/8-1:0] st_req_strb,
  output logic                    st_resp_valid
);
  localparam int AW  = $clog2(DEPTH);
  localparam int MCW = (MISS_EVERY > 1) ? $clog2(MISS_EVERY) : 1;
  localparam int LCW = $clog2(MISS_LAT + 1);
  localparam int NB  = XLEN_WIDTH / 8;

  typedef enum logic {IDLE, MISS_WAIT} state_t;
  state_t state, state_nxt;

  logic [XLEN_WIDTH-1:0] mem [DEPTH];
  logic [MCW-1:0]        mcnt;
  logic [LCW-1:0]        lat_cnt;
  logic [AW-1:0]         ld_idx, st_idx, miss_idx;
  logic [TAG_W-1:0]      miss_tag, hit_tag_q;
  logic [XLEN_WIDTH-1:0] hit_data_q;
  logic                  hit_v_q, hit_q;
  logic                  ld_acc, is_miss, fill;

  assign ld_idx  = ld_req_addr[2 +: AW];
  assign st_idx  = st_req_addr[2 +: AW];
  assign ld_acc  = ld_req_valid && ld_req_ready;
  assign is_miss = (MISS_EVERY != 0) && (mcnt == MCW'(MISS_EVERY - 1));

  logic unused_addr_bits;
  assign unused_addr_bits = ^{ld_req_addr[XLEN_WIDTH-1:AW+2], ld_req_addr[1:0],
                              st_req_addr[XLEN_WIDTH-1:AW+2], st_req_addr[1:0]};

  // The fill cycle reopens the request port, so a new load may overlap it.
  assign fill            = (state == MISS_WAIT) && (lat_cnt == '0);
  assign ld_req_ready    = (state == IDLE) || fill;
  assign load_dmem_stall = (state == MISS_WAIT) && !fill;
  assign st_req_ready    = 1'b1;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      state_nxt = IDLE;
      MISS_WAIT: if (lat_cnt == '0) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    if (ld_acc && is_miss) state_nxt = MISS_WAIT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      mcnt          <= '0;
      lat_cnt       <= '0;
      miss_idx      <= '0;
      miss_tag      <= '0;
      hit_v_q       <= 1'b0;
      hit_q         <= 1'b0;
      hit_tag_q     <= '0;
      hit_data_q    <= '0;
      st_resp_valid <= 1'b0;
    end else begin
      state         <= state_nxt;
      st_resp_valid <= st_req_valid;
      hit_v_q       <= ld_acc;
      hit_q         <= ld_acc && !is_miss;
      if (state == MISS_WAIT && lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
      if (ld_acc) begin
        hit_tag_q <= ld_req_tag;
        if (MISS_EVERY != 0) mcnt <= is_miss ? '0 : mcnt + 1'b1;
        if (is_miss) begin
          miss_idx <= ld_idx;
          miss_tag <= ld_req_tag;
          lat_cnt  <= LCW'(MISS_LAT);
        end else begin
          hit_data_q <= mem[ld_idx];
        end
      end
    end
  end

  // Same-edge store/load: the nonblocking write leaves the hit read pre-store.
  always_ff @(posedge clk) begin
    if (!rst && st_req_valid)
      for (int b = 0; b < NB; b++)
        if (st_req_strb[b]) mem[st_idx][8*b +: 8] <= st_req_data[8*b +: 8];
  end

  // Fill word is read in the fill cycle itself so stores during the wait show.
  assign ld_hit_valid  = hit_v_q;
  assign ld_hit        = hit_q;
  assign ld_hit_tag    = hit_tag_q;
  assign ld_data_valid = hit_q || fill;
  assign ld_data       = fill ? mem[miss_idx] : hit_data_q;
  assign ld_data_tag   = fill ? miss_tag : hit_tag_q;
endmodule

// File: tb/tb_falco_dmem_responder.sv
// Bench for falco_dmem_responder: directed scenarios then random traffic,
// all checked against a timeline model (load count modulo, due-cycle of fill).
module tb_falco_dmem_responder;
  localparam int XW = 32, DEPTH = 4096, TW = 4, ME = 8, LAT = 6;
  localparam int AW = $clog2(DEPTH);

  logic clk = 1'b0, rst = 1'b1;
  logic ld_req_valid = 1'b0, ld_req_ready;
  logic [XW-1:0] ld_req_addr = '0;
  logic [TW-1:0] ld_req_tag = '0;
  logic ld_hit_valid, ld_hit, ld_data_valid, load_dmem_stall;
  logic [TW-1:0] ld_hit_tag, ld_data_tag;
  logic [XW-1:0] ld_data;
  logic st_req_valid = 1'b0, st_req_ready, st_resp_valid;
  logic [XW-1:0] st_req_addr = '0, st_req_data = '0;
  logic [XW/8-1:0] st_req_strb = '0;

  falco_dmem_responder #(.XLEN_WIDTH(XW), .DEPTH(DEPTH), .TAG_W(TW),
                         .MISS_EVERY(ME), .MISS_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready),
    .ld_req_addr(ld_req_addr), .ld_req_tag(ld_req_tag),
    .ld_hit_valid(ld_hit_valid), .ld_hit(ld_hit), .ld_hit_tag(ld_hit_tag),
    .ld_data_valid(ld_data_valid), .ld_data(ld_data), .ld_data_tag(ld_data_tag),
    .load_dmem_stall(load_dmem_stall),
    .st_req_valid(st_req_valid), .st_req_ready(st_req_ready),
    .st_req_addr(st_req_addr), .st_req_data(st_req_data),
    .st_req_strb(st_req_strb), .st_resp_valid(st_resp_valid)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  logic [XW-1:0] mm [DEPTH];
  int cyc = 0, nloads = 0;
  bit miss_pend = 0;
  int miss_due = 0, miss_idx = 0;
  logic [TW-1:0] miss_tag = '0;
  bit e_hv = 0, e_hit = 0, e_st = 0;
  logic [TW-1:0] e_htag = '0;
  logic [XW-1:0] e_hdata = '0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", name, obs, exp, cyc);
    end
  endtask

  // Check this cycle's outputs at the falling edge, then advance the model.
  task automatic tick();
    bit fill, rdy, miss;
    int idx, sidx;
    @(negedge clk);
    fill = miss_pend && (cyc == miss_due);
    rdy  = !miss_pend || fill;
    chk("ld_req_ready", ld_req_ready, rdy);
    chk("st_req_ready", st_req_ready, 1);
    chk("stall", load_dmem_stall, miss_pend && !fill);
    chk("hit_valid", ld_hit_valid, e_hv);
    if (e_hv) begin
      chk("hit", ld_hit, e_hit);
      chk("hit_tag", ld_hit_tag, e_htag);
    end
    chk("data_valid", ld_data_valid, (e_hv && e_hit) || fill);
    if (fill) begin
      chk("fill_data", ld_data, mm[miss_idx]);
      chk("fill_tag", ld_data_tag, miss_tag);
    end else if (e_hv && e_hit) begin
      chk("hit_data", ld_data, e_hdata);
      chk("data_tag", ld_data_tag, e_htag);
    end
    chk("st_resp", st_resp_valid, e_st);
    if (fill) miss_pend = 0;
    e_hv = ld_req_valid && rdy;
    e_hit = 0;
    if (e_hv) begin
      idx  = int'(ld_req_addr[2 +: AW]);
      miss = (ME != 0) && ((nloads % ME) == ME - 1);
      nloads++;
      e_hit = !miss; e_htag = ld_req_tag; e_hdata = mm[idx];
      if (miss) begin
        miss_pend = 1; miss_due = cyc + 1 + LAT; miss_tag = ld_req_tag; miss_idx = idx;
      end
    end
    e_st = st_req_valid;
    if (st_req_valid) begin
      sidx = int'(st_req_addr[2 +: AW]);
      for (int b = 0; b < XW/8; b++)
        if (st_req_strb[b]) mm[sidx][8*b +: 8] = st_req_data[8*b +: 8];
    end
    @(posedge clk); #1; cyc++;
  endtask

  task automatic do_reset();
    ld_req_valid = 0; st_req_valid = 0; rst = 1;
    @(posedge clk); #1; rst = 0; cyc++;
    nloads = 0; miss_pend = 0; e_hv = 0; e_hit = 0; e_st = 0;
  endtask

  task automatic ld(input bit v, input logic [XW-1:0] a, input logic [TW-1:0] t);
    ld_req_valid = v; ld_req_addr = a; ld_req_tag = t;
  endtask

  task automatic st(input bit v, input logic [XW-1:0] a, input logic [XW-1:0] d,
                    input logic [XW/8-1:0] s);
    st_req_valid = v; st_req_addr = a; st_req_data = d; st_req_strb = s;
  endtask

  initial begin
    int stall_cnt;
    logic [XW-1:0] a;
    repeat (2) @(posedge clk);
    do_reset();
    chk("rst_data", ld_data, 0);
    chk("rst_data_tag", ld_data_tag, 0);
    chk("rst_hit_tag", ld_hit_tag, 0);
    chk("rst_hit", ld_hit, 0);
    chk("rst_ready", ld_req_ready, 1);
    tick();

    // Preload every word the bench reads.
    for (int i = 0; i < 32; i++) begin
      st(1, XW'(i*4), $urandom(), 4'hF); tick();
    end
    st(1, 32'h8, 32'hCAFE0008, 4'hF); tick();
    st(1, 32'h40, 32'h1, 4'hF); tick();
    st(1, 32'h200, 32'h0, 4'hF); tick();
    st(0, 0, 0, 0); tick();

    // 1: store then sub-word-offset load hits with the full word.
    st(1, 32'h100, 32'hDEADBEEF, 4'hF); tick();
    st(0, 0, 0, 0); ld(1, 32'h102, 4'd3); tick();
    ld(0, 0, 0);
    chk("t1_hit", ld_hit, 1);
    chk("t1_data", ld_data, 32'hDEADBEEF);
    chk("t1_tag", ld_data_tag, 3);
    chk("t1_htag", ld_hit_tag, 3);
    tick();

    // 2: eight back-to-back loads, the eighth misses.
    do_reset();
    for (int i = 0; i < 8; i++) begin ld(1, XW'(i*4), TW'(i)); tick(); end
    ld(0, 0, 0);
    chk("t2_miss_hv", ld_hit_valid, 1);
    chk("t2_miss_hit", ld_hit, 0);
    chk("t2_miss_dv", ld_data_valid, 0);
    stall_cnt = 0;
    for (int i = 0; i < LAT; i++) begin
      if (load_dmem_stall) stall_cnt++;
      tick();
    end
    chk("t2_stall_cycles", stall_cnt, LAT);
    chk("t2_fill_dv", ld_data_valid, 1);
    chk("t2_fill_tag", ld_data_tag, 7);
    chk("t2_fill_stall", load_dmem_stall, 0);
    tick();

    // 3: partial store during a miss is visible in the fill; loads held off.
    for (int i = 0; i < 7; i++) begin ld(1, XW'((8+i)*4), TW'(i)); tick(); end
    ld(1, 32'h200, 4'd9); tick();
    ld(1, 32'h0, 4'd10);
    chk("t3_ready_low", ld_req_ready, 0);
    st(1, 32'h200, 32'h11223344, 4'b0011); tick();
    st(0, 0, 0, 0);
    for (int i = 0; i < LAT - 1; i++) tick();
    chk("t3_fill_dv", ld_data_valid, 1);
    chk("t3_fill_data", ld_data, 32'h00003344);
    chk("t3_fill_tag", ld_data_tag, 9);
    tick();
    ld(0, 0, 0); tick();

    // 4: same-cycle store and load to one word returns the old word.
    st(1, 32'h40, 32'hAAAA5555, 4'hF); ld(1, 32'h40, 4'd1); tick();
    st(0, 0, 0, 0); ld(1, 32'h40, 4'd2);
    chk("t4_old", ld_data, 32'h1);
    tick();
    ld(0, 0, 0);
    chk("t4_new", ld_data, 32'hAAAA5555);
    chk("t4_tag", ld_data_tag, 2);

    // 5: address wraps modulo DEPTH*4.
    ld(1, XW'(DEPTH*4 + 8), 4'd5); tick();
    ld(0, 0, 0);
    chk("t5_wrap", ld_data, 32'hCAFE0008);
    tick();

    // 6: reset two cycles into a miss drops the fill.
    do_reset();
    for (int i = 0; i < 8; i++) begin ld(1, XW'(i*4), TW'(i)); tick(); end
    ld(0, 0, 0); tick(); tick();
    do_reset();
    chk("t6_stall", load_dmem_stall, 0);
    chk("t6_ready", ld_req_ready, 1);
    for (int i = 0; i < LAT + 2; i++) tick();
    ld(1, 32'h10, 4'd4); tick();
    ld(0, 0, 0);
    chk("t6_hit", ld_hit, 1);
    chk("t6_dv", ld_data_valid, 1);
    tick();

    // Random mixed traffic with random upper/low address bits.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      a = $urandom(); a[2 +: AW] = AW'($urandom_range(0, 31));
      ld($urandom_range(0, 1) == 1, a, TW'($urandom()));
      a = $urandom(); a[2 +: AW] = AW'($urandom_range(0, 31));
      st($urandom_range(0, 2) == 0, a, $urandom(), 4'($urandom()));
      tick();
    end
    ld(0, 0, 0); st(0, 0, 0, 0);
    repeat (LAT + 2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
